// File: rtl/tt_um_islam_ihfaz_serial_adder.sv
// Bit-serial 8-bit adder: operands arrive LSB first, one bit pair per valid cycle;
// the completed sum word and final carry are published when the eighth bit is consumed.
module tt_um_islam_ihfaz_serial_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       carry_q, carry_d;
    logic [7:0] sr_q, sr_d;
    logic       sum_bit_q, sum_bit_d;
    logic       carry_out_q, carry_out_d;
    logic       word_done_q, word_done_d;
    logic [7:0] word_q, word_d;

    logic       a_bit_s, b_bit_s, bit_valid_s, clear_s;
    logic       carry_in_s, sum_s, maj_s;
    logic       unused_s;

    assign a_bit_s     = ui_in[0];
    assign b_bit_s     = ui_in[1];
    assign bit_valid_s = ui_in[2];
    assign clear_s     = ui_in[3];
    assign unused_s    = ^{ui_in[7:4], uio_in};

    // Only a word already in progress contributes its stored carry.
    assign carry_in_s = (state_q == ACCUM) ? carry_q : 1'b0;
    assign sum_s      = fa_sum(a_bit_s, b_bit_s, carry_in_s);
    assign maj_s      = fa_carry(a_bit_s, b_bit_s, carry_in_s);

    // Next-state and datapath update for one consumed bit, clear, or hold.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        carry_d     = carry_q;
        sr_d        = sr_q;
        sum_bit_d   = sum_bit_q;
        carry_out_d = carry_out_q;
        word_done_d = word_done_q;
        word_d      = word_q;
        if (ena) begin
            if (clear_s) begin
                state_d     = IDLE;
                bit_cnt_d   = 3'd0;
                carry_d     = 1'b0;
                sr_d        = 8'h00;
                word_done_d = 1'b0;
            end else if (bit_valid_s) begin
                sum_bit_d = sum_s;
                if (bit_cnt_q == 3'd7) begin
                    word_d      = {sum_s, sr_q[7:1]};
                    carry_out_d = maj_s;
                    word_done_d = 1'b1;
                    bit_cnt_d   = 3'd0;
                    carry_d     = 1'b0;
                    sr_d        = 8'h00;
                    state_d     = DONE;
                end else begin
                    sr_d        = {sum_s, sr_q[7:1]};
                    carry_d     = maj_s;
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    word_done_d = 1'b0;
                    state_d     = ACCUM;
                end
            end else begin
                word_done_d = 1'b0;
                case (state_q)
                    DONE:    state_d = IDLE;
                    ACCUM:   state_d = ACCUM;
                    IDLE:    state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; reset clears everything including the published word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            carry_q     <= 1'b0;
            sr_q        <= 8'h00;
            sum_bit_q   <= 1'b0;
            carry_out_q <= 1'b0;
            word_done_q <= 1'b0;
            word_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            carry_q     <= carry_d;
            sr_q        <= sr_d;
            sum_bit_q   <= sum_bit_d;
            carry_out_q <= carry_out_d;
            word_done_q <= word_done_d;
            word_q      <= word_d;
        end
    end

    assign uo_out  = {carry_q, bit_cnt_q, (state_q == ACCUM), word_done_q, carry_out_q, sum_bit_q};
    assign uio_out = word_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: doc/tt_um_islam_ihfaz_serial_adder.md
TT_UM_ISLAM_IHFAZ_SERIAL_ADDER -- requirements
Module: tt_um_islam_ihfaz_serial_adder

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset (rst_n).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  design enable; when 0, all state SHALL hold and inputs SHALL be ignored.
REQ-005 ui_in  input  8  [0] a_bit, [1] b_bit, [2] bit_valid, [3] clear, [7:4] unused and ignored.
REQ-006 uio_in  input  8  unused and ignored.
REQ-007 uo_out  output  8  [0] sum_bit, [1] carry_out, [2] word_done, [3] busy, [6:4] bit_cnt, [7] carry_state.
REQ-008 uio_out  output  8  last completed 8-bit sum word.
REQ-009 uio_oe  output  8  SHALL be constant 8'hFF.

Function
REQ-010 The block SHALL add two 8-bit operands presented bit-serially, LSB first, one bit pair per cycle with bit_valid=1.
REQ-011 FSM states: IDLE (bit_cnt=0, carry=0), ACCUM (bit_cnt 1..7 consumed), DONE (one cycle, word just completed).
REQ-012 In IDLE or DONE, bit_valid=1 SHALL consume bit 0 using carry-in 0 and go to ACCUM with bit_cnt=1.
REQ-013 In ACCUM, bit_valid=1 SHALL consume the next bit using the stored carry; bit_valid=0 SHALL hold all state (gaps allowed, no timeout).
REQ-014 Per consumed bit: sum_bit <= a^b^c, carry <= majority(a,b,c), sum bit shifted into an 8-bit shift register MSB-in, bit_cnt increments.
REQ-015 sum_bit (uo_out[0]) SHALL be registered and appear one cycle after the consuming edge; it SHALL hold until the next consumed bit.
REQ-016 On the 8th consumed bit: uio_out <= completed word, carry_out <= final carry, word_done = 1 for exactly the next cycle, bit_cnt wraps to 0, internal carry cleared, state -> DONE.
REQ-017 DONE SHALL return to IDLE after one cycle unless bit_valid=1, which starts the next word (back-to-back words, no bubble).
REQ-018 uio_out and carry_out SHALL hold their values until the next word completes; partial words SHALL never update them.
REQ-019 clear=1 (with ena=1) SHALL abort any word: bit_cnt=0, carry=0, shift register=0, state IDLE; uio_out/carry_out retained.
REQ-020 clear and bit_valid both 1 in one cycle: clear SHALL win and the bit SHALL be discarded.
REQ-021 busy SHALL be 1 exactly in ACCUM; carry_state SHALL reflect the internal carry register.
REQ-022 bit_cnt output SHALL equal the number of bits consumed in the current word (0..7).

Reset
REQ-023 rst_n=0 SHALL immediately force: state IDLE, bit_cnt 0, carry 0, shift register 0, uo_out 8'h00, uio_out 8'h00.
REQ-024 Reset mid-word SHALL discard the partial word; after release, the first valid bit SHALL be treated as bit 0.
REQ-025 Reset SHALL be asynchronous on assertion; release SHALL be clean with respect to clk (first active edge after deassertion behaves as from IDLE).

Verification
REQ-026 A=0x5A, B=0x33 streamed with bit_valid every cycle -> uio_out=0x8D, carry_out=0, word_done one-cycle pulse after 8th bit.
REQ-027 A=0xFF, B=0x01 -> uio_out=0x00, carry_out=1; next word A=0x01,B=0x01 back-to-back -> 0x02, carry_out=0 (carry not leaked).
REQ-028 A=0x0F, B=0x0F with random bit_valid gaps of 0-3 cycles -> uio_out=0x1E, bit_cnt increments only on valid bits.
REQ-029 Clear asserted after 4 bits (same cycle as bit_valid) -> bit_cnt=0, busy=0, uio_out unchanged; fresh word 0x10+0x20 -> 0x30.
REQ-030 rst_n pulsed low after 5 bits -> all outputs 0 immediately; subsequent 0x80+0x80 -> uio_out=0x00, carry_out=1.
REQ-031 ena=0 for 3 cycles mid-word with bit_valid toggling -> no state change; resuming completes correct sum.
